// File: rtl/seq_pkg.sv
// Shared types and default sizing for the serial-pattern job scheduler.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_SEQ_W    = 4;
    localparam int DEF_WAIT_CYC = 2;

endpackage

// File: rtl/seq_scheduler_rr_arbiter.sv
// Combinational round-robin selector: prio is the first index considered
// (one past the last grant); returns a one-hot winner, or zero when idle.
module rr_arbiter
    import seq_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    prio,
    output logic [N_REQ-1:0] win
);

    logic w_found;

    // Two passes: indices at/after prio first, then the wrapped-around remainder.
    always_comb begin
        win     = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_found && req[i] && (i >= 32'(prio))) begin
                win[i]  = 1'b1;
                w_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_found && req[i]) begin
                win[i]  = 1'b1;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scheduler.sv
// Grants one requester at a time, streams its pattern LSB-first to an external
// sequence detector, then reports whether the detector matched in the response window.
module seq_scheduler
    import seq_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int SEQ_W    = DEF_SEQ_W,
    parameter int WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*SEQ_W-1:0] pat,
    output logic [N_REQ-1:0]       gnt,
    output logic                   a,
    output logic                   det_clr,
    input  logic                   det_valid,
    output logic                   done,
    output logic                   hit,
    output logic                   busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;
    localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [SEQ_W-1:0] r_shift;
    logic [BW-1:0]    r_bcnt;
    logic [WW-1:0]    r_wcnt;
    logic             r_hacc;

    logic [N_REQ-1:0] w_win;
    logic [IW-1:0]    w_win_idx;
    logic [IW-1:0]    w_next_ptr;
    logic [SEQ_W-1:0] w_win_pat;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req  (req),
        .prio (r_ptr),
        .win  (w_win)
    );

    always_comb begin
        w_win_idx = '0;
        w_win_pat = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_win[i]) begin
                w_win_idx = IW'(i);
                w_win_pat = pat[i*SEQ_W +: SEQ_W];
            end
        end
        w_next_ptr = (w_win_idx == IW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_wcnt  <= '0;
            r_hacc  <= 1'b0;
            gnt     <= '0;
            a       <= 1'b0;
            det_clr <= 1'b1;
            done    <= 1'b0;
            hit     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    a       <= 1'b0;
                    det_clr <= 1'b0;
                    if (|req) begin
                        r_state <= S_LOAD;
                        r_ptr   <= w_next_ptr;
                        r_shift <= w_win_pat;
                        r_hacc  <= 1'b0;
                        gnt     <= w_win;
                        det_clr <= 1'b1;
                        hit     <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_SHIFT;
                    r_bcnt  <= '0;
                    det_clr <= 1'b0;
                    a       <= r_shift[0];
                    r_shift <= r_shift >> 1;
                end
                S_SHIFT: begin
                    // a already carries bit r_bcnt; the final bit's cycle hands off to WAIT.
                    if (r_bcnt == BW'(SEQ_W - 1)) begin
                        r_state <= S_WAIT;
                        r_wcnt  <= '0;
                        a       <= 1'b0;
                    end else begin
                        r_bcnt  <= r_bcnt + 1'b1;
                        a       <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                S_WAIT: begin
                    r_hacc <= r_hacc | det_valid;
                    if (r_wcnt == WW'(WAIT_CYC - 1)) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        hit     <= r_hacc | det_valid;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    gnt     <= '0;
                    done    <= 1'b0;
                    hit     <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
